// File: rtl/mnacidpro_valve_seq.sv
// Valve/pump sequencer for the mnacidpro extraction chip: one bead/lysis/wash/elute
// pass per collect chamber, with an all-closed settle hold after every pumping step.
module mnacidpro_valve_seq #(
    parameter int SIZE          = 5,
    parameter int PHASE_CYCLES  = 2,
    parameter int BEAD_STROKES  = 2,
    parameter int LYSIS_STROKES = 3,
    parameter int WASH_STROKES  = 2,
    parameter int ELUTE_STROKES = 2,
    parameter int SETTLE_CYCLES = 3,
    localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    output logic          lysis_ctrl,
    output logic          wash_ctrl,
    output logic          elute_ctrl,
    output logic          dead_end_ctrl,
    output logic          vertical_ctrl,
    output logic          horiz_ctrl,
    output logic          waste_ctrl,
    output logic          bead_ctrl,
    output logic          loop_exit_ctrl,
    output logic          bead_trap_ctrl,
    output logic          collect_ctrl,
    output logic [2:0]    pump,
    output logic [IW-1:0] collect_idx,
    output logic          busy,
    output logic          done,
    output logic          aborted
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_BEAD   = 3'd1,
        S_LYSIS  = 3'd2,
        S_WASH   = 3'd3,
        S_ELUTE  = 3'd4,
        S_SETTLE = 3'd5
    } state_t;

    localparam int B_LYSIS = 10, B_WASH = 9, B_ELUTE = 8, B_DEAD_END = 7, B_VERTICAL = 6;
    localparam int B_HORIZ = 5, B_WASTE = 4, B_BEAD = 3, B_LOOP_EXIT = 2, B_BEAD_TRAP = 1;
    localparam int B_COLLECT = 0;

    localparam logic [15:0]   PC_LAST     = 16'(PHASE_CYCLES - 1);
    localparam logic [15:0]   SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST    = IW'(SIZE - 1);

    function automatic logic [15:0] stroke_last(input state_t s);
        case (s)
            S_BEAD:  stroke_last = 16'(BEAD_STROKES - 1);
            S_LYSIS: stroke_last = 16'(LYSIS_STROKES - 1);
            S_WASH:  stroke_last = 16'(WASH_STROKES - 1);
            S_ELUTE: stroke_last = 16'(ELUTE_STROKES - 1);
            default: stroke_last = 16'd0;
        endcase
    endfunction

    function automatic state_t step_after(input state_t s);
        case (s)
            S_BEAD:  step_after = S_LYSIS;
            S_LYSIS: step_after = S_WASH;
            S_WASH:  step_after = S_ELUTE;
            S_ELUTE: step_after = S_BEAD;
            default: step_after = S_IDLE;
        endcase
    endfunction

    // 0 = open; everything not opened by the current step stays pressurized.
    function automatic logic [10:0] valves_for(input state_t s);
        logic [10:0] v;
        v = 11'h7FF;
        case (s)
            S_BEAD: begin
                v[B_BEAD] = 1'b0; v[B_HORIZ] = 1'b0; v[B_BEAD_TRAP] = 1'b0; v[B_WASTE] = 1'b0;
            end
            S_LYSIS: begin
                v[B_LYSIS] = 1'b0; v[B_VERTICAL] = 1'b0; v[B_LOOP_EXIT] = 1'b0;
                v[B_BEAD_TRAP] = 1'b0; v[B_WASTE] = 1'b0;
            end
            S_WASH: begin
                v[B_WASH] = 1'b0; v[B_HORIZ] = 1'b0; v[B_BEAD_TRAP] = 1'b0; v[B_WASTE] = 1'b0;
            end
            S_ELUTE: begin
                v[B_ELUTE] = 1'b0; v[B_DEAD_END] = 1'b0; v[B_BEAD_TRAP] = 1'b0; v[B_COLLECT] = 1'b0;
            end
            default: v = 11'h7FF;
        endcase
        valves_for = v;
    endfunction

    // Gray-like six-phase peristaltic pattern: one bit flips per phase step.
    function automatic logic [2:0] pump_for(input state_t s, input logic [2:0] ph);
        if ((s == S_IDLE) || (s == S_SETTLE)) begin
            pump_for = 3'b111;
        end else begin
            case (ph)
                3'd0:    pump_for = 3'b011;
                3'd1:    pump_for = 3'b001;
                3'd2:    pump_for = 3'b101;
                3'd3:    pump_for = 3'b100;
                3'd4:    pump_for = 3'b110;
                3'd5:    pump_for = 3'b010;
                default: pump_for = 3'b111;
            endcase
        end
    endfunction

    state_t          state_q, state_d, ret_q, ret_d;
    logic [15:0]     cyc_q, cyc_d, str_q, str_d;
    logic [2:0]      ph_q, ph_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            done_d, aborted_d;
    logic [10:0]     valves_q;
    logic [2:0]      pump_q;
    logic            busy_q, done_q, aborted_q;

    // Next-state logic: step timing, settle return, pass advance and abort override.
    always_comb begin
        state_d   = state_q;
        ret_d     = ret_q;
        cyc_d     = cyc_q;
        ph_d      = ph_q;
        str_d     = str_q;
        idx_d     = idx_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_BEAD;
                    idx_d   = '0;
                    cyc_d   = 16'd0;
                    ph_d    = 3'd0;
                    str_d   = 16'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BEAD, S_LYSIS, S_WASH, S_ELUTE: begin
                if (cyc_q == PC_LAST) begin
                    cyc_d = 16'd0;
                    if (ph_q == 3'd5) begin
                        ph_d = 3'd0;
                        if (str_q == stroke_last(state_q)) begin
                            str_d   = 16'd0;
                            ret_d   = step_after(state_q);
                            state_d = S_SETTLE;
                        end else begin
                            str_d = str_q + 16'd1;
                        end
                    end else begin
                        ph_d = ph_q + 3'd1;
                    end
                end else begin
                    cyc_d = cyc_q + 16'd1;
                end
            end
            S_SETTLE: begin
                if (cyc_q == SETTLE_LAST) begin
                    cyc_d = 16'd0;
                    ph_d  = 3'd0;
                    str_d = 16'd0;
                    if ((ret_q == S_BEAD) && (idx_q == IDX_LAST)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else if (ret_q == S_BEAD) begin
                        state_d = S_BEAD;
                        idx_d   = idx_q + IW'(1);
                    end else begin
                        state_d = ret_q;
                    end
                end else begin
                    cyc_d = cyc_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (abort && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            ret_d     = S_BEAD;
            cyc_d     = 16'd0;
            ph_d      = 3'd0;
            str_d     = 16'd0;
            idx_d     = '0;
            done_d    = 1'b0;
            aborted_d = 1'b1;
        end else begin
            aborted_d = 1'b0;
        end
    end

    // State, counters and registered outputs derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ret_q     <= S_BEAD;
            cyc_q     <= 16'd0;
            ph_q      <= 3'd0;
            str_q     <= 16'd0;
            idx_q     <= '0;
            valves_q  <= 11'h7FF;
            pump_q    <= 3'b111;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            cyc_q     <= cyc_d;
            ph_q      <= ph_d;
            str_q     <= str_d;
            idx_q     <= idx_d;
            valves_q  <= valves_for(state_d);
            pump_q    <= pump_for(state_d, ph_d);
            busy_q    <= (state_d != S_IDLE);
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign lysis_ctrl     = valves_q[B_LYSIS];
    assign wash_ctrl      = valves_q[B_WASH];
    assign elute_ctrl     = valves_q[B_ELUTE];
    assign dead_end_ctrl  = valves_q[B_DEAD_END];
    assign vertical_ctrl  = valves_q[B_VERTICAL];
    assign horiz_ctrl     = valves_q[B_HORIZ];
    assign waste_ctrl     = valves_q[B_WASTE];
    assign bead_ctrl      = valves_q[B_BEAD];
    assign loop_exit_ctrl = valves_q[B_LOOP_EXIT];
    assign bead_trap_ctrl = valves_q[B_BEAD_TRAP];
    assign collect_ctrl   = valves_q[B_COLLECT];
    assign pump           = pump_q;
    assign collect_idx    = idx_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign aborted        = aborted_q;

endmodule

// File: tb/tb_mnacidpro_valve_seq.sv
// Bench for mnacidpro_valve_seq: directed vectors, timeline sequences and random
// start/abort/reset traffic checked against a run-timeline reference model.
module tb_mnacidpro_valve_seq;

    localparam int SIZE = 5, PC = 2, NB = 2, NL = 3, NW = 2, NE = 2, NS = 3;
    localparam int IW = 3;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
    logic lysis_ctrl, wash_ctrl, elute_ctrl, dead_end_ctrl, vertical_ctrl, horiz_ctrl;
    logic waste_ctrl, bead_ctrl, loop_exit_ctrl, bead_trap_ctrl, collect_ctrl;
    logic [2:0] pump;
    logic [IW-1:0] collect_idx;
    logic busy, done, aborted;

    mnacidpro_valve_seq dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .lysis_ctrl(lysis_ctrl), .wash_ctrl(wash_ctrl), .elute_ctrl(elute_ctrl),
        .dead_end_ctrl(dead_end_ctrl), .vertical_ctrl(vertical_ctrl), .horiz_ctrl(horiz_ctrl),
        .waste_ctrl(waste_ctrl), .bead_ctrl(bead_ctrl), .loop_exit_ctrl(loop_exit_ctrl),
        .bead_trap_ctrl(bead_trap_ctrl), .collect_ctrl(collect_ctrl), .pump(pump),
        .collect_idx(collect_idx), .busy(busy), .done(done), .aborted(aborted)
    );

    always #5 clk = ~clk;

    wire [10:0] dv = {lysis_ctrl, wash_ctrl, elute_ctrl, dead_end_ctrl, vertical_ctrl, horiz_ctrl,
                      waste_ctrl, bead_ctrl, loop_exit_ctrl, bead_trap_ctrl, collect_ctrl};

    int total = 0, bad = 0;
    logic [10:0] all1, v_bead, v_lys, v_wash, v_elute;
    logic [2:0] pat [6];
    int seglen [8];
    int P, RUN;

    // reference model: a run is just a cycle count k into a fixed timeline
    bit m_run, m_done, m_ab;
    int m_k;
    logic [IW-1:0] e_idx;
    logic [2:0] e_pump;
    logic [10:0] e_val;
    logic [2:0] prev_pump = 3'b111;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input logic r, input logic s, input logic a);
        int off, sg;
        m_done = 1'b0;
        m_ab   = 1'b0;
        if (r) begin
            m_run = 1'b0; m_k = 0; e_idx = '0;
        end else if (m_run) begin
            if (a) begin
                m_run = 1'b0; m_ab = 1'b1; e_idx = '0;
            end else begin
                m_k++;
                if (m_k > RUN) begin
                    m_run = 1'b0; m_done = 1'b1;
                end
            end
        end else if (s && !a) begin
            m_run = 1'b1; m_k = 1;
        end
        e_pump = 3'b111;
        e_val  = all1;
        if (m_run) begin
            e_idx = IW'((m_k - 1) / P);
            off = (m_k - 1) % P;
            sg = 0;
            while (off >= seglen[sg]) begin
                off -= seglen[sg];
                sg++;
            end
            if (sg % 2 == 0) begin
                e_pump = pat[(off / PC) % 6];
                case (sg / 2)
                    0: e_val = v_bead;
                    1: e_val = v_lys;
                    2: e_val = v_wash;
                    default: e_val = v_elute;
                endcase
            end
        end
    endtask

    task automatic step(input logic r, input logic s, input logic a);
        rst = r; start = s; abort = a;
        @(posedge clk);
        model_update(r, s, a);
        #1;
        check("model", {12'd0, busy, done, aborted, collect_idx, pump, dv},
              {12'd0, m_run, m_done, m_ab, e_idx, e_pump, e_val});
        if (pump != 3'b111 && prev_pump != 3'b111)
            check("pump_hamming_le1", 32'(((pump ^ prev_pump) & (((pump ^ prev_pump) - 3'd1))) != 3'd0), 32'd0);
        if (bead_ctrl == 1'b0 || elute_ctrl == 1'b0)
            check("bead_elute_excl", 32'(bead_ctrl | elute_ctrl), 32'd1);
        prev_pump = pump;
    endtask

    typedef struct {
        logic r, s, a, busy, ab;
        logic [2:0]  pump;
        logic [10:0] val;
    } vec_t;
    vec_t tbl [13];

    initial begin
        int c, ndone, done_cyc;
        all1 = 11'h7FF;
        // bit order: lysis wash elute dead_end vertical horiz waste bead loop_exit bead_trap collect
        v_bead = all1;  v_bead[3] = 1'b0; v_bead[5] = 1'b0; v_bead[1] = 1'b0; v_bead[4] = 1'b0;
        v_lys = all1;   v_lys[10] = 1'b0; v_lys[6] = 1'b0; v_lys[2] = 1'b0; v_lys[1] = 1'b0; v_lys[4] = 1'b0;
        v_wash = all1;  v_wash[9] = 1'b0; v_wash[5] = 1'b0; v_wash[1] = 1'b0; v_wash[4] = 1'b0;
        v_elute = all1; v_elute[8] = 1'b0; v_elute[7] = 1'b0; v_elute[1] = 1'b0; v_elute[0] = 1'b0;
        pat = '{3'b011, 3'b001, 3'b101, 3'b100, 3'b110, 3'b010};
        seglen = '{NB*6*PC, NS, NL*6*PC, NS, NW*6*PC, NS, NE*6*PC, NS};
        P = 0;
        foreach (seglen[i]) P += seglen[i];
        RUN = SIZE * P;
        m_run = 1'b0; m_k = 0; e_idx = '0;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b111, all1};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b111, all1};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b011, v_bead};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b011, v_bead};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001, v_bead};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b001, v_bead};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b101, v_bead};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'b111, all1};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b111, all1};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b111, all1};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b111, all1};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b011, v_bead};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b111, all1};

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].r, tbl[i].s, tbl[i].a);
            check($sformatf("vec%0d", i), {16'd0, busy, aborted, pump, dv},
                  {16'd0, tbl[i].busy, tbl[i].ab, tbl[i].pump, tbl[i].val});
        end

        // reset then ten idle cycles
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
        check("idle_state", {17'd0, busy, done, aborted, pump, dv}, {17'd0, 3'b000, 3'b111, all1});

        // full run with an ignored mid-run start
        ndone = 0; done_cyc = -1;
        step(1'b0, 1'b1, 1'b0);
        c = 1;
        check("c1_pump", 32'(pump), 32'(3'b011));
        while (c < 620) begin
            step(1'b0, (c == 100), 1'b0);
            c++;
            if (done) begin
                ndone++;
                done_cyc = c;
            end
            if (c == 3)  check("c3_pump", 32'(pump), 32'(3'b001));
            if (c == 5)  check("c5_pump", 32'(pump), 32'(3'b101));
            if (c == 25) check("c25_settle", {18'd0, pump, dv}, {18'd0, 3'b111, all1});
            if (c == 28) check("c28_lysis", 32'(dv), 32'(v_lys));
            if (c == 121 || c == 241 || c == 361 || c == 481)
                check("idx_step", 32'(collect_idx), 32'((c - 1) / 120));
        end
        check("done_count", 32'(ndone), 32'd1);
        check("done_cycle", 32'(done_cyc), 32'd601);

        // abort during lysis
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        for (int i = 2; i <= 50; i++) step(1'b0, 1'b0, 1'b0);
        check("c50_lysis", 32'(dv), 32'(v_lys));
        step(1'b0, 1'b0, 1'b1);
        check("abort_c51", {16'd0, busy, aborted, collect_idx, pump, dv},
              {16'd0, 1'b0, 1'b1, 3'd0, 3'b111, all1});
        step(1'b0, 1'b0, 1'b0);
        check("abort_pulse_1cyc", 32'(aborted), 32'd0);
        step(1'b0, 1'b1, 1'b1);
        check("idle_start_abort", {30'd0, busy, aborted}, 32'd0);

        // random traffic
        for (int i = 0; i < 5000; i++)
            step(($urandom_range(0, 999) == 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 299) == 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
